// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU op codes,
// mux select encodings and the control FSM state type.
package mc_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_J     = 6'b000010;

    // alu_op codes consumed by the ALU control decoder
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_RTYP = 3'b010;
    localparam logic [2:0] ALU_ADDI = 3'b011;
    localparam logic [2:0] ALU_ORI  = 3'b100;
    localparam logic [2:0] ALU_ANDI = 3'b101;
    localparam logic [2:0] ALU_SLTI = 3'b110;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        IMM_EXEC  = 4'd9,
        IMM_WB    = 4'd10,
        JUMP      = 4'd11
    } state_e;

    // ALU operation for the immediate-arithmetic class, keyed by opcode
    function automatic logic [2:0] imm_alu_op(input logic [5:0] opc);
        case (opc)
            OPC_ORI:  imm_alu_op = ALU_ORI;
            OPC_ANDI: imm_alu_op = ALU_ANDI;
            OPC_SLTI: imm_alu_op = ALU_SLTI;
            default:  imm_alu_op = ALU_ADDI;
        endcase
    endfunction

endpackage

// File: rtl/mc_perf_counters.sv
// Free-running cycle counter and retired-instruction counter for the
// multicycle control FSM; both wrap and clear on synchronous reset.
module mc_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (instr_done) begin
                instr_cnt <= instr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Define MULTICYCLE_CONTROL_PERF_EN to add the cycle/instruction counters.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output state_e     debug_state
`ifdef MULTICYCLE_CONTROL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("multicycle_control: CNT_W must be at least 1");
    end

    state_e     state;
    state_e     state_next;
    logic [5:0] opc_q;
    logic       instr_done;

    // The IR may change once DECODE has passed; later states use this copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            opc_q <= OPC_RTYPE;
        end else begin
            state <= state_next;
            if (state == DECODE) begin
                opc_q <= opcode;
            end
        end
    end

    always_comb begin
        state_next    = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        alu_op        = ALU_ADD;
        pc_src        = PC_SRC_ALU;
        illegal_op    = 1'b0;

        // Reset silences every output, even when the register still holds
        // a mid-instruction state, so an aborted instruction writes nothing.
        if (!rst) begin
            unique case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready) state_next = DECODE;
                end
                DECODE: begin
                    alu_src_b = SRC_B_IMM_SH;
                    case (opcode)
                        OPC_LW, OPC_SW: state_next = MEM_ADDR;
                        OPC_RTYPE:      state_next = R_EXEC;
                        OPC_BEQ:        state_next = BRANCH;
                        OPC_ADDI, OPC_ORI, OPC_ANDI, OPC_SLTI:
                                        state_next = IMM_EXEC;
                        OPC_J:          state_next = JUMP;
                        default: begin
                            state_next = FETCH;
                            illegal_op = 1'b1;
                        end
                    endcase
                end
                MEM_ADDR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRC_B_IMM;
                    state_next = (opc_q == OPC_SW) ? MEM_WRITE : MEM_READ;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) state_next = MEM_WB;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_next = FETCH;
                end
                MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready) state_next = FETCH;
                end
                R_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_RTYP;
                    state_next = R_WB;
                end
                R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    state_next = FETCH;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_src        = PC_SRC_ALUOUT;
                    state_next    = FETCH;
                end
                IMM_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRC_B_IMM;
                    alu_op     = imm_alu_op(opc_q);
                    state_next = IMM_WB;
                end
                IMM_WB: begin
                    reg_write  = 1'b1;
                    state_next = FETCH;
                end
                JUMP: begin
                    pc_write   = 1'b1;
                    pc_src     = PC_SRC_JUMP;
                    state_next = FETCH;
                end
                default: state_next = FETCH;
            endcase
        end
    end

    assign debug_state = state;
    // A FETCH-stall self-loop is not a retirement; every other entry is.
    assign instr_done  = !rst && (state != FETCH) && (state_next == FETCH);

`ifdef MULTICYCLE_CONTROL_PERF_EN
    mc_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk       (clk),
        .rst       (rst),
        .instr_done(instr_done),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );
`else
    logic unused_instr_done;
    assign unused_instr_done = instr_done;
`endif

endmodule
